// File: rtl/bits_nibble_serializer.sv
// bits_nibble_serializer: takes one WORD_W-bit word per valid/ready
// handshake and emits it MSB-first as NIB_W-bit beats on a second one.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_word
//   upstream; out_valid/out_ready/out_nib/out_last downstream;
//   word_cnt = 8-bit wrapping count of completed words.
// Option: define BITS_SER_PARITY_EN to add out_par (= ^out_nib).
module bits_nibble_serializer #(
    parameter int WORD_W = 41,
    parameter int NIB_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NIB_W-1:0]  out_nib,
    output logic              out_last,
    output logic [7:0]        word_cnt
`ifdef BITS_SER_PARITY_EN
    ,
    output logic              out_par
`endif
);

    localparam int BEATS = (WORD_W + NIB_W - 1) / NIB_W;
    localparam int SH_W  = BEATS * NIB_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_n;
    logic [SH_W-1:0]    r_shreg;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_word_cnt;
    logic               w_last;
    logic               w_xfer;
    logic               w_last_xfer;
    logic               w_load;

    // The pad sits above the word, so zero-extension at load
    // places it at the MSB end and the top slice is beat 0.
    assign w_last      = (r_state == SEND) && (r_cnt == '0);
    assign w_xfer      = (r_state == SEND) && out_ready;
    assign w_last_xfer = w_xfer && w_last;

    // Ready depends on out_ready in the same cycle so a new word can
    // be taken on the final beat with no bubble.
    assign in_ready = rst_n && ((r_state == IDLE) || w_last_xfer);
    assign w_load   = in_valid && in_ready;

    assign out_valid = (r_state == SEND);
    assign out_last  = w_last;
    assign out_nib   = r_shreg[SH_W-1 -: NIB_W];
    assign word_cnt  = r_word_cnt;

`ifdef BITS_SER_PARITY_EN
    // out_nib is a pure slice of r_shreg, so parity tracks it
    // through loads, shifts, stalls and reset.
    assign out_par = ^out_nib;
`endif

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_n = SEND;
                end
            end
            SEND: begin
                if (w_last_xfer && !w_load) begin
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_shreg <= SH_W'(in_word);
            r_cnt   <= CNT_W'(BEATS - 1);
        end else if (w_xfer) begin
            r_shreg <= r_shreg << NIB_W;
            r_cnt   <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
        end else if (w_last_xfer) begin
            r_word_cnt <= r_word_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_bits_nibble_serializer.sv
// Bench for bits_nibble_serializer: queue model of expected beats
// checked every cycle, plus hand-computed literal expectations.
module tb_bits_nibble_serializer;

    localparam int WORD_W = 41;
    localparam int NIB_W  = 4;
    localparam int BEATS  = 11;

    typedef struct {
        logic [3:0] nib;
        logic       last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD_W-1:0] in_word = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [3:0]        out_nib;
    logic              out_last;
    logic [7:0]        word_cnt;
`ifdef BITS_SER_PARITY_EN
    logic              out_par;
`endif

    bits_nibble_serializer #(
        .WORD_W(WORD_W),
        .NIB_W (NIB_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_word  (in_word),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_nib  (out_nib),
        .out_last (out_last),
        .word_cnt (word_cnt)
`ifdef BITS_SER_PARITY_EN
        ,
        .out_par  (out_par)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    beat_t      exp_q[$];
    int         m_wcnt = 0;
    int         cyc = 0;
    logic [3:0] got_q[$];
    logic       got_l[$];
    int         got_t[$];
    logic       got_p[$];

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: an accepted word becomes BEATS nibbles, MSB-first,
    // taken arithmetically from the zero-padded word value.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_wcnt = 0;
        end else begin
            cyc++;
            if (out_valid && out_ready) begin
                got_q.push_back(out_nib);
                got_l.push_back(out_last);
                got_t.push_back(cyc);
`ifdef BITS_SER_PARITY_EN
                got_p.push_back(out_par);
`endif
                if (exp_q.size() > 0) begin
                    if (exp_q[0].last) m_wcnt = (m_wcnt + 1) % 256;
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                for (int i = 0; i < BEATS; i++) begin
                    beat_t b;
                    longint sh;
                    sh = longint'(in_word) >> ((BEATS - 1 - i) * NIB_W);
                    b.nib  = 4'(sh & 15);
                    b.last = (i == BEATS - 1);
                    exp_q.push_back(b);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_rdy;
            exp_rdy = (exp_q.size() == 0) ||
                      (exp_q[0].last && out_ready);
            chk("in_ready", in_ready, exp_rdy);
            chk("word_cnt", word_cnt, m_wcnt);
            chk("out_valid", out_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                chk("out_nib", out_nib, exp_q[0].nib);
                chk("out_last", out_last, exp_q[0].last);
`ifdef BITS_SER_PARITY_EN
                chk("out_par", out_par, ^exp_q[0].nib);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_got();
        got_q.delete();
        got_l.delete();
        got_t.delete();
        got_p.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clr_got();
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w);
        logic acc;
        int n;
        in_valid = 1'b1;
        in_word = w;
        n = 0;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 100);
        if (!acc) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_beats(input int k);
        int n = 0;
        while (got_q.size() < k && n < 200) begin
            tick();
            n++;
        end
        if (got_q.size() < k) chk("beat_timeout", got_q.size(), k);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("idle_timeout", 0, 1);
    endtask

    logic [3:0] lit1[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    logic       litp[11] = '{1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1};

    initial begin
        int nl;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_nib", out_nib, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_word_cnt", word_cnt, 0);
        do_reset();
        out_ready = 1'b1;

        // 1: plain word
        send_word(41'h123456789AB);
        wait_idle();
        chk("t1_nbeats", got_q.size(), 11);
        nl = 0;
        for (int i = 0; i < got_q.size() && i < 11; i++) begin
            chk("t1_beat", got_q[i], lit1[i]);
            nl += int'(got_l[i]);
        end
        chk("t1_nlast", nl, 1);
        chk("t1_last_pos", got_l[10], 1);
        chk("t1_word_cnt", word_cnt, 1);
        chk("t1_in_ready", in_ready, 1);

        // 2: stall at beat 5
        do_reset();
        send_word(41'h123456789AB);
        wait_beats(4);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t2_hold_nib", out_nib, 4'h5);
            chk("t2_hold_valid", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        wait_idle();
        chk("t2_nbeats", got_q.size(), 11);
        for (int i = 0; i < got_q.size() && i < 11; i++)
            chk("t2_beat", got_q[i], lit1[i]);

        // 3: back-to-back, no bubble
        do_reset();
        send_word(41'h123456789AB);
        send_word(41'h0FEDCBA9876);
        wait_idle();
        chk("t3_nbeats", got_q.size(), 22);
        nl = 0;
        for (int i = 0; i + 1 < got_t.size(); i++)
            if (got_t[i + 1] != got_t[i] + 1) nl++;
        chk("t3_gaps", nl, 0);
        if (got_q.size() >= 12) begin
            chk("t3_b10", got_q[10], 4'hB);
            chk("t3_b11", got_q[11], 4'h0);
        end
        chk("t3_word_cnt", word_cnt, 2);

        // 4: reset mid-word
        do_reset();
        send_word(41'h1FFFFFFFFFF);
        wait_beats(6);
        chk("t4_b0", got_q[0], 4'h1);
        chk("t4_b1", got_q[1], 4'hF);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", out_valid, 0);
        chk("t4_rst_wcnt", word_cnt, 0);
        chk("t4_rst_last", out_last, 0);
        chk("t4_rst_rdy", in_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        clr_got();
        send_word(41'h0);
        wait_idle();
        chk("t4_nbeats", got_q.size(), 11);
        nl = 0;
        for (int i = 0; i < got_q.size(); i++)
            nl += int'(got_q[i]);
        chk("t4_zero_sum", nl, 0);
        chk("t4_word_cnt", word_cnt, 1);

        // 5: word_cnt wrap
        do_reset();
        for (int i = 0; i < 255; i++) send_word(41'h0);
        wait_idle();
        chk("t5_cnt255", word_cnt, 255);
        send_word(41'h0);
        wait_idle();
        chk("t5_wrap", word_cnt, 0);

`ifdef BITS_SER_PARITY_EN
        // 6: parity
        do_reset();
        chk("t6_rst_par", out_par, 0);
        send_word(41'h123456789AB);
        wait_idle();
        chk("t6_npar", got_p.size(), 11);
        for (int i = 0; i < got_p.size() && i < 11; i++)
            chk("t6_par", got_p[i], litp[i]);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
